// File: rtl/rob_pkg.sv
// rob_pkg: shared constants and types for the reorder-buffer commit scheduler.
//   ROB_SIZE / ROB_ADDR_W : default buffer depth and tag width
//   robTag_t / robCount_t : tag and occupancy types
//   robSchedState_t       : scheduler state (RUN, FLUSH)
package rob_pkg;

    localparam int ROB_SIZE   = 32;
    localparam int ROB_ADDR_W = $clog2(ROB_SIZE);

    typedef logic [ROB_ADDR_W-1:0] robTag_t;
    typedef logic [ROB_ADDR_W:0]   robCount_t;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } robSchedState_t;

endpackage

// File: rtl/rob_ptr_counter.sv
// rob_ptr_counter: wrapping ring pointer.
//   clk_i, reset_i : clock, asynchronous active-high reset (ptr -> 0)
//   clr_i          : synchronous clear to 0, wins over inc_i
//   inc_i          : advance by one; wraps naturally at 2**W
//   ptr_o          : current pointer value
module rob_ptr_counter #(
    parameter int W = 5
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] ptr_o
);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)    ptr_o <= '0;
        else if (clr_i) ptr_o <= '0;
        else if (inc_i) ptr_o <= ptr_o + W'(1);
    end

endmodule

// File: rtl/rob_commit_scheduler.sv
// rob_commit_scheduler: allocate / complete / commit sequencing for the ROB.
//   dispatch*  : allocation at the tail; dispatchTag_o is always the tail
//   wb*        : completion by tag; ignored for unallocated tags
//   commit*    : in-order retirement from the head, one per cycle
//   flush_i    : empties the buffer; one FLUSH cycle follows the last flush
//   count_o / empty_o / full_o : occupancy; all ROBsize entries usable
module rob_commit_scheduler
    import rob_pkg::*;
#(
    parameter int ROBsize  = ROB_SIZE,
    parameter int addrSize = $clog2(ROBsize)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                dispatchValid_i,
    output logic                dispatchReady_o,
    output logic [addrSize-1:0] dispatchTag_o,
    input  logic                wbValid_i,
    input  logic [addrSize-1:0] wbTag_i,
    output logic                commitValid_o,
    output logic [addrSize-1:0] commitTag_o,
    input  logic                commitReady_i,
    input  logic                flush_i,
    output logic [addrSize:0]   count_o,
    output logic                empty_o,
    output logic                full_o
);

    localparam logic [addrSize:0] FULL_CNT = (addrSize+1)'(ROBsize);
    localparam logic [addrSize:0] ONE_CNT  = (addrSize+1)'(1);

    robSchedState_t       state_q;
    logic [ROBsize-1:0]   valid_q;
    logic [ROBsize-1:0]   done_q;
    logic [addrSize:0]    count_q;
    logic [addrSize-1:0]  head;
    logic [addrSize-1:0]  tail;
    logic                 dispatch_fire;
    logic                 commit_fire;
    logic                 wb_fire;

    // Occupancy is tracked by count, so head==tail is ambiguous on its own.
    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    assign dispatchReady_o = (state_q == RUN) & ~full_o & ~flush_i;
    assign dispatchTag_o   = tail;
    assign dispatch_fire   = dispatchValid_i & dispatchReady_o;

    // Registered done bits only: a completion is visible to commit next cycle.
    assign commitValid_o = (state_q == RUN) & ~flush_i & valid_q[head] & done_q[head];
    assign commitTag_o   = head;
    assign commit_fire   = commitValid_o & commitReady_i;

    assign wb_fire = wbValid_i & valid_q[wbTag_i] & ~flush_i;

    rob_ptr_counter #(.W(addrSize)) u_head (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr_i   (flush_i),
        .inc_i   (commit_fire),
        .ptr_o   (head)
    );

    rob_ptr_counter #(.W(addrSize)) u_tail (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr_i   (flush_i),
        .inc_i   (dispatch_fire),
        .ptr_o   (tail)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= RUN;
        else         state_q <= flush_i ? FLUSH : RUN;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else if (flush_i) begin
            count_q <= '0;
        end else begin
            case ({dispatch_fire, commit_fire})
                2'b10:   count_q <= count_q + ONE_CNT;
                2'b01:   count_q <= count_q - ONE_CNT;
                default: count_q <= count_q;
            endcase
        end
    end

    // Later assignments win: a writeback racing the commit of the same head
    // entry must not leave a stale done bit behind the retired slot.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid_q <= '0;
            done_q  <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            if (wb_fire) done_q[wbTag_i] <= 1'b1;
            if (commit_fire) begin
                valid_q[head] <= 1'b0;
                done_q[head]  <= 1'b0;
            end
            if (dispatch_fire) begin
                valid_q[tail] <= 1'b1;
                done_q[tail]  <= 1'b0;
            end
        end
    end

endmodule
